// File: rtl/pt_ring_fifo.sv
// Parametrised circular FIFO for ring-stop buffering; 1-cycle write-to-read latency, occupancy/almost-full flags, sticky ovf/udf errors.
// Backpressure: writes are accepted while not full, or while full with a simultaneous pop; PT_FIFO_BYPASS_EN adds empty-FIFO cut-through.
module pt_ring_fifo #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 4,
   parameter int AFUL_TH = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       iWrEn,
   input  logic [WIDTH-1:0]           iWrDat,
   input  logic                       iRdEn,
   input  logic                       iClrErr,
   output logic                       oFul,
   output logic                       oEmpty,
   output logic                       oAlmFul,
   output logic [$clog2(DEPTH+1)-1:0] oCnt,
   output logic [WIDTH-1:0]           oRdDat,
   output logic                       oOvf,
   output logic                       oUdf
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]    r_cnt;
   logic             r_ful, r_empty, r_alm, r_ovf, r_udf;

   logic             w_byp, w_wr_acc, w_rd_acc, w_ovf_set, w_udf_set;
   logic [CW-1:0]    w_cnt_nxt;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

`ifdef PT_FIFO_BYPASS_EN
   assign w_byp = r_empty & iWrEn & iRdEn;
`else
   assign w_byp = 1'b0;
`endif

   assign w_wr_acc  = iWrEn & (~r_ful | iRdEn) & ~w_byp;
   assign w_rd_acc  = iRdEn & ~r_empty;
   assign w_ovf_set = iWrEn & r_ful & ~iRdEn;
   assign w_udf_set = iRdEn & r_empty & ~w_byp;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_wr_acc && !w_rd_acc)
         w_cnt_nxt = r_cnt + CW'(1);
      else if (!w_wr_acc && w_rd_acc)
         w_cnt_nxt = r_cnt - CW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_ful    <= 1'b0;
         r_empty  <= 1'b1;
         r_alm    <= 1'b0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= f_inc(r_wr_ptr);
         if (w_rd_acc) r_rd_ptr <= f_inc(r_rd_ptr);
         r_cnt   <= w_cnt_nxt;
         r_ful   <= (w_cnt_nxt == CW'(DEPTH));
         r_empty <= (w_cnt_nxt == '0);
         r_alm   <= (w_cnt_nxt >= CW'(AFUL_TH));
         // A coincident set beats the clear.
         r_ovf   <= w_ovf_set | (r_ovf & ~iClrErr);
         r_udf   <= w_udf_set | (r_udf & ~iClrErr);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[r_wr_ptr] <= iWrDat;
   end

   always_comb begin
      oRdDat = '0;
      if (!r_empty) oRdDat = r_mem[r_rd_ptr];
`ifdef PT_FIFO_BYPASS_EN
      if (r_empty && iWrEn) oRdDat = iWrDat;
`endif
   end

   assign oFul    = r_ful;
   assign oEmpty  = r_empty;
   assign oAlmFul = r_alm;
   assign oCnt    = r_cnt;
   assign oOvf    = r_ovf;
   assign oUdf    = r_udf;

endmodule

// File: tb/tb_pt_ring_fifo.sv
// Bench for pt_ring_fifo: directed scenarios plus random traffic on DEPTH=4 and DEPTH=3 instances, checked against a queue model.
module tb_pt_ring_fifo;

   logic       clk, rst;
   logic       wr4, rd4, clr4, ful4, emp4, alm4, ovf4, udf4;
   logic [7:0] dat4, rdd4;
   logic [2:0] cnt4;
   logic       wr3, rd3, clr3, ful3, emp3, alm3, ovf3, udf3;
   logic [7:0] dat3, rdd3;
   logic [1:0] cnt3;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] q4[$];
   logic [7:0] q3[$];
   bit m_ovf4, m_udf4, m_ovf3, m_udf3;

   pt_ring_fifo #(.WIDTH(8), .DEPTH(4), .AFUL_TH(3)) u_dut4 (
      .clk(clk), .rst(rst), .iWrEn(wr4), .iWrDat(dat4), .iRdEn(rd4), .iClrErr(clr4),
      .oFul(ful4), .oEmpty(emp4), .oAlmFul(alm4), .oCnt(cnt4), .oRdDat(rdd4),
      .oOvf(ovf4), .oUdf(udf4));

   pt_ring_fifo #(.WIDTH(8), .DEPTH(3), .AFUL_TH(2)) u_dut3 (
      .clk(clk), .rst(rst), .iWrEn(wr3), .iWrDat(dat3), .iRdEn(rd3), .iClrErr(clr3),
      .oFul(ful3), .oEmpty(emp3), .oAlmFul(alm3), .oCnt(cnt3), .oRdDat(rdd3),
      .oOvf(ovf3), .oUdf(udf3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock of DUT4 traffic; the model advances from the FIFO rules and all outputs are compared.
   task automatic step4(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
      bit full, empty, byp, wacc, racc;
      logic [15:0] obs, exp_v;
      wr4 = wr; dat4 = d; rd4 = rd; clr4 = clr;
      full  = (q4.size() == 4);
      empty = (q4.size() == 0);
      byp   = 1'b0;
`ifdef PT_FIFO_BYPASS_EN
      byp = empty && wr && rd;
      #1;
      if (empty && wr) begin
         n_vec++;
         if (rdd4 !== d) begin
            n_err++;
            $display("FAIL bypass4 oRdDat got=%h exp=%h", rdd4, d);
         end
      end
`endif
      wacc = wr && (!full || rd) && !byp;
      racc = rd && !empty;
      @(posedge clk);
      m_ovf4 = (wr && full && !rd) || (m_ovf4 && !clr);
      m_udf4 = (rd && empty && !byp) || (m_udf4 && !clr);
      if (racc) void'(q4.pop_front());
      if (wacc) q4.push_back(d);
      #1;
      obs   = {cnt4, emp4, ful4, alm4, ovf4, udf4, rdd4};
      exp_v = {3'(q4.size()), q4.size() == 0, q4.size() == 4, q4.size() >= 3,
               m_ovf4, m_udf4, (q4.size() != 0) ? q4[0] : 8'h00};
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL sb4 {cnt,emp,ful,alm,ovf,udf,dat} got=%h exp=%h", obs, exp_v);
      end
      wr4 = 0; rd4 = 0; clr4 = 0;
   endtask

   task automatic step3(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
      bit full, empty, byp, wacc, racc;
      logic [14:0] obs, exp_v;
      wr3 = wr; dat3 = d; rd3 = rd; clr3 = clr;
      full  = (q3.size() == 3);
      empty = (q3.size() == 0);
      byp   = 1'b0;
`ifdef PT_FIFO_BYPASS_EN
      byp = empty && wr && rd;
`endif
      wacc = wr && (!full || rd) && !byp;
      racc = rd && !empty;
      @(posedge clk);
      m_ovf3 = (wr && full && !rd) || (m_ovf3 && !clr);
      m_udf3 = (rd && empty && !byp) || (m_udf3 && !clr);
      if (racc) void'(q3.pop_front());
      if (wacc) q3.push_back(d);
      #1;
      obs   = {cnt3, emp3, ful3, alm3, ovf3, udf3, rdd3};
      exp_v = {2'(q3.size()), q3.size() == 0, q3.size() == 3, q3.size() >= 2,
               m_ovf3, m_udf3, (q3.size() != 0) ? q3[0] : 8'h00};
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL sb3 {cnt,emp,ful,alm,ovf,udf,dat} got=%h exp=%h", obs, exp_v);
      end
      n_vec++;
      if (cnt3 > 2'd3 || cnt3 === 2'bxx) begin
         n_err++;
         $display("FAIL cnt3_bound got=%0d max=3", cnt3);
      end
      wr3 = 0; rd3 = 0; clr3 = 0;
   endtask

   task automatic test_reset();
      #12;
      n_vec++;
      if ({cnt4, emp4, ful4, alm4, ovf4, udf4, rdd4} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         n_err++;
         $display("FAIL reset_idle got=%h exp=%h", {cnt4, emp4, ful4, alm4, ovf4, udf4, rdd4}, 16'h1000);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      step4(1, 8'h11, 0, 0);
      step4(1, 8'h22, 0, 0);
      step4(1, 8'h33, 0, 0);
      #2 rst = 1'b0;
      #1;
      n_vec++;
      if ({cnt4, emp4, ful4, alm4, ovf4, udf4, rdd4} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         n_err++;
         $display("FAIL reset_async got=%h exp=%h", {cnt4, emp4, ful4, alm4, ovf4, udf4, rdd4}, 16'h1000);
      end
      q4.delete(); q3.delete();
      m_ovf4 = 0; m_udf4 = 0; m_ovf3 = 0; m_udf3 = 0;
      #3 rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_fill_drain();
      logic [7:0] wd;
      for (int i = 0; i < 4; i++) begin
         wd = 8'hA1 + 8'(i);
         step4(1, wd, 0, 0);
         n_vec++;
         if (cnt4 !== 3'(i + 1) || alm4 !== (i >= 2) || ful4 !== (i == 3) || rdd4 !== 8'hA1) begin
            n_err++;
            $display("FAIL fill%0d cnt=%0d alm=%b ful=%b dat=%h exp cnt=%0d alm=%b ful=%b dat=a1",
                     i, cnt4, alm4, ful4, rdd4, i + 1, i >= 2, i == 3);
         end
      end
      for (int i = 0; i < 4; i++) begin
         wd = 8'hA1 + 8'(i);
         n_vec++;
         if (rdd4 !== wd) begin
            n_err++;
            $display("FAIL drain%0d got=%h exp=%h", i, rdd4, wd);
         end
         step4(0, 8'h00, 1, 0);
      end
      n_vec++;
      if (emp4 !== 1'b1) begin
         n_err++;
         $display("FAIL drain_empty got=%b exp=1", emp4);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 4; i++) step4(1, 8'(8'hB1 + 8'(i)), 0, 0);
      step4(1, 8'hB0, 0, 0);
      n_vec++;
      if (ovf4 !== 1'b1 || cnt4 !== 3'd4 || rdd4 !== 8'hB1) begin
         n_err++;
         $display("FAIL ovf got ovf=%b cnt=%0d dat=%h exp ovf=1 cnt=4 dat=b1", ovf4, cnt4, rdd4);
      end
      step4(0, 8'h00, 0, 1);
      n_vec++;
      if (ovf4 !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_clr got=%b exp=0", ovf4);
      end
   endtask

   task automatic test_full_rw();
      step4(1, 8'hC5, 1, 0);
      n_vec++;
      if (cnt4 !== 3'd4 || rdd4 !== 8'hB2) begin
         n_err++;
         $display("FAIL full_rw cnt=%0d dat=%h exp cnt=4 dat=b2", cnt4, rdd4);
      end
      for (int i = 0; i < 3; i++) step4(0, 8'h00, 1, 0);
      n_vec++;
      if (rdd4 !== 8'hC5) begin
         n_err++;
         $display("FAIL wrap_last got=%h exp=c5", rdd4);
      end
      step4(0, 8'h00, 1, 0);
   endtask

   task automatic test_empty_rw();
      step4(1, 8'hD7, 1, 0);
      n_vec++;
`ifdef PT_FIFO_BYPASS_EN
      if (udf4 !== 1'b0 || cnt4 !== 3'd0) begin
         n_err++;
         $display("FAIL empty_rw udf=%b cnt=%0d exp udf=0 cnt=0", udf4, cnt4);
      end
`else
      if (udf4 !== 1'b1 || cnt4 !== 3'd1 || rdd4 !== 8'hD7) begin
         n_err++;
         $display("FAIL empty_rw udf=%b cnt=%0d dat=%h exp udf=1 cnt=1 dat=d7", udf4, cnt4, rdd4);
      end
`endif
      step4(0, 8'h00, 1, 1);
      step4(0, 8'h00, 0, 1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 200; i++)
         step4(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(0, 7) == 0);
   endtask

   task automatic test_depth3_random();
      for (int i = 0; i < 100; i++)
         step3(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(0, 9) == 0);
   endtask

   initial begin
      rst = 1'b0;
      wr4 = 0; rd4 = 0; clr4 = 0; dat4 = '0;
      wr3 = 0; rd3 = 0; clr3 = 0; dat3 = '0;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_full_rw();
      test_empty_rw();
      test_back_to_back();
      test_depth3_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
